// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared definitions for the execute-stage hazard/forwarding controller and for
// decode:
//   - RV32I major opcode constants used by the classification functions
//   - sb_entry_t : one scoreboard entry {valid, rd, is_load}
//   - writes_rd / reads_rs1 / reads_rs2 : operand usage per instruction
//   - decode_entry : builds the scoreboard record for an issuing instruction
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Major opcodes (inst[6:0]).
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_CSR       = 7'b1110011;

    // One in-flight destination. A bubble is simply an entry with valid = 0.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

    // Field extractors keep the bit positions in one place.
    function automatic logic [4:0] rd_of(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    // An instruction that targets x0 produces nothing worth forwarding.
    function automatic logic writes_rd(input logic [31:0] inst);
        logic op_writes;
        case (inst[6:0])
            OPC_ARI_RTYPE,
            OPC_ARI_ITYPE,
            OPC_LOAD,
            OPC_JALR,
            OPC_LUI,
            OPC_AUIPC,
            OPC_JAL:  op_writes = 1'b1;
            default:  op_writes = 1'b0;
        endcase
        return op_writes && (inst[11:7] != 5'd0);
    endfunction

    // CSR immediate forms (funct3[2] = 1) carry a zimm in the rs1 field.
    function automatic logic reads_rs1(input logic [31:0] inst);
        logic uses;
        case (inst[6:0])
            OPC_ARI_RTYPE,
            OPC_ARI_ITYPE,
            OPC_LOAD,
            OPC_STORE,
            OPC_BRANCH,
            OPC_JALR: uses = 1'b1;
            OPC_CSR:  uses = ~inst[14];
            default:  uses = 1'b0;
        endcase
        return uses;
    endfunction

    function automatic logic reads_rs2(input logic [31:0] inst);
        logic uses;
        case (inst[6:0])
            OPC_ARI_RTYPE,
            OPC_STORE,
            OPC_BRANCH: uses = 1'b1;
            default:    uses = 1'b0;
        endcase
        return uses;
    endfunction

    // Scoreboard record for an instruction; non-writers become bubbles.
    function automatic sb_entry_t decode_entry(input logic [31:0] inst);
        sb_entry_t e;
        e.valid   = writes_rd(inst);
        e.rd      = e.valid ? rd_of(inst) : 5'd0;
        e.is_load = e.valid && (inst[6:0] == OPC_LOAD);
        return e;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
//
// Priority compare of one source register against every scoreboard entry.
// The youngest matching entry (lowest index) wins.
//
// Ports:
//   enable      in   operand is actually read by a valid issuing instruction
//   src         in   source register number
//   entries     in   scoreboard, entry 0 youngest
//   sel         out  0 = register file, k = forward from entry k-1
//   is_load_hit out  the winning entry holds a load
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                    enable,
    input  logic [4:0]              src,
    input  sb_entry_t [DEPTH-1:0]   entries,
    output logic [SEL_W-1:0]        sel,
    output logic                    is_load_hit
);

    // Scan oldest to youngest so a younger match overwrites an older one.
    // NOTE: every output gets a default before the loop; without it a
    // no-match path would leave sel unassigned and infer a latch.
    always_comb begin
        sel         = '0;
        is_load_hit = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (enable && (src != 5'd0) && entries[k].valid && (entries[k].rd == src)) begin
                sel         = SEL_W'(k + 1);
                is_load_hit = entries[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the execute stage. Keeps a shift
// register of in-flight destination registers (entry 0 youngest), produces a
// per-operand forwarding select, a load-use stall, and a saturating count of
// stalled cycles.
//
// Parameters:
//   DEPTH         scoreboard entries (stages after issue that can forward), 1..8
//   LOAD_LATENCY  stage index where load data becomes forwardable, 1..DEPTH
//   KILL_STAGES   youngest entries (index < KILL_STAGES) cleared by flush
//   CNT_W         stall counter width
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   issue_valid  in   issue_inst is a real instruction
//   issue_inst   in   instruction entering execute
//   flush        in   branch/jump redirect
//   fwd_sel_ra   out  rs1 select: 0 = regfile, k = entry k-1
//   fwd_sel_rb   out  rs2 select, same encoding
//   stall        out  hold issue this cycle, insert a bubble
//   stall_count  out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH        = 3,
    parameter int LOAD_LATENCY = 2,
    parameter int KILL_STAGES  = 1,
    parameter int CNT_W        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [31:0]                   issue_inst,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_ra,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_rb,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_count
);

    localparam int SEL_W = $clog2(DEPTH + 1);

    // A load in entry k shows up as sel = k+1, so "k < LOAD_LATENCY" is
    // the same as "sel <= LOAD_LATENCY".
    localparam logic [SEL_W-1:0] LOAD_SEL_LIMIT = SEL_W'(LOAD_LATENCY);

    sb_entry_t [DEPTH-1:0] entries;
    sb_entry_t [DEPTH-1:0] entries_next;
    sb_entry_t             issue_rec;

    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             load_hit_a;
    logic             load_hit_b;
    logic             load_use;

    // ---------------------------------------------------------------------
    // Operand matching
    // ---------------------------------------------------------------------
    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_match_rs1 (
        .enable      (issue_valid && reads_rs1(issue_inst)),
        .src         (rs1_of(issue_inst)),
        .entries     (entries),
        .sel         (sel_a),
        .is_load_hit (load_hit_a)
    );

    hazard_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_match_rs2 (
        .enable      (issue_valid && reads_rs2(issue_inst)),
        .src         (rs2_of(issue_inst)),
        .entries     (entries),
        .sel         (sel_b),
        .is_load_hit (load_hit_b)
    );

    // ---------------------------------------------------------------------
    // Stall and select outputs (combinational, zero-cycle latency)
    // ---------------------------------------------------------------------
    assign load_use = (load_hit_a && (sel_a <= LOAD_SEL_LIMIT)) ||
                      (load_hit_b && (sel_b <= LOAD_SEL_LIMIT));

    // A redirect discards the consumer anyway, so it overrides the stall.
    assign stall = load_use && !flush;

    // Selects are meaningless while stalling; zero keeps them quiet.
    assign fwd_sel_ra = stall ? '0 : sel_a;
    assign fwd_sel_rb = stall ? '0 : sel_b;

    // ---------------------------------------------------------------------
    // Scoreboard advance
    // ---------------------------------------------------------------------
    assign issue_rec = decode_entry(issue_inst);

    always_comb begin
        entries_next[0] = (issue_valid && !stall && !flush) ? issue_rec : SB_BUBBLE;
        // Entries younger than KILL_STAGES belong to the wrong path on a
        // flush and are invalidated as they shift; older ones survive.
        for (int k = 1; k < DEPTH; k++) begin
            if (flush && ((k - 1) < KILL_STAGES)) begin
                entries_next[k] = SB_BUBBLE;
            end else begin
                entries_next[k] = entries[k - 1];
            end
        end
    end

    // NOTE: the scoreboard is a handful of flops, not a RAM, and its valid
    // bits must clear asynchronously so stall drops the instant rst rises;
    // hence the whole array is in the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= {DEPTH{SB_BUBBLE}};
        end else begin
            // NOTE: non-blocking assignment so every entry samples the
            // pre-edge value of its neighbour, giving a true shift register.
            entries <= entries_next;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating stall counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard: a directed vector table, hand
// sequences for flush / async reset / counter saturation, and a randomized
// phase checked against a history-queue reference model.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;
    localparam int LL    = 2;
    localparam int KILL  = 1;

    localparam bit [6:0] OP_R     = 7'h33;
    localparam bit [6:0] OP_I     = 7'h13;
    localparam bit [6:0] OP_LD    = 7'h03;
    localparam bit [6:0] OP_ST    = 7'h23;
    localparam bit [6:0] OP_BR    = 7'h63;
    localparam bit [6:0] OP_JALR  = 7'h67;
    localparam bit [6:0] OP_JAL   = 7'h6f;
    localparam bit [6:0] OP_LUI   = 7'h37;
    localparam bit [6:0] OP_AUIPC = 7'h17;
    localparam bit [6:0] OP_SYS   = 7'h73;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic        flush;
    logic [1:0]  sel_ra, sel_rb, sat_sel_ra, sat_sel_rb;
    logic        stall, sat_stall;
    logic [31:0] stall_count;
    logic [1:0]  sat_count;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .flush       (flush),
        .fwd_sel_ra  (sel_ra),
        .fwd_sel_rb  (sel_rb),
        .stall       (stall),
        .stall_count (stall_count)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_inst  (issue_inst),
        .flush       (flush),
        .fwd_sel_ra  (sat_sel_ra),
        .fwd_sel_rb  (sat_sel_rb),
        .stall       (sat_stall),
        .stall_count (sat_count)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit [31:0] enc(input bit [6:0] op, input int rd, input int rs1,
                                      input int rs2, input bit [2:0] f3);
        return {7'd0, 5'(rs2), 5'(rs1), f3, 5'(rd), op};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a history of issued results, youngest first.
    // ------------------------------------------------------------------
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } m_ent_t;

    m_ent_t hist[$];
    int     m_count;

    function automatic bit m_writes(input bit [31:0] i);
        return (i[6:0] inside {OP_R, OP_I, OP_LD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL})
               && (i[11:7] != 0);
    endfunction

    function automatic bit m_rs1(input bit [31:0] i);
        return (i[6:0] inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR})
               || (i[6:0] == OP_SYS && !i[14]);
    endfunction

    function automatic bit m_rs2(input bit [31:0] i);
        return i[6:0] inside {OP_R, OP_ST, OP_BR};
    endfunction

    // Age of the youngest in-flight producer of src, or -1.
    function automatic void m_find(input bit used, input int src, output int age, output bit ld);
        age = -1;
        ld  = 1'b0;
        if (!used || src == 0) return;
        for (int a = 0; a < hist.size(); a++) begin
            if (hist[a].v && hist[a].rd == src) begin
                age = a;
                ld  = hist[a].ld;
                return;
            end
        end
    endfunction

    function automatic void m_predict(input bit v, input bit [31:0] i, input bit fl,
                                      output int ea, output int eb, output bit es);
        int age_a, age_b;
        bit ld_a, ld_b;
        m_find(v && m_rs1(i), int'(i[19:15]), age_a, ld_a);
        m_find(v && m_rs2(i), int'(i[24:20]), age_b, ld_b);
        es = !fl && ((age_a >= 0 && ld_a && age_a < LL) || (age_b >= 0 && ld_b && age_b < LL));
        ea = es ? 0 : age_a + 1;
        eb = es ? 0 : age_b + 1;
    endfunction

    function automatic void m_advance(input bit v, input bit [31:0] i, input bit fl, input bit es);
        m_ent_t n;
        if (fl) for (int k = 0; k < KILL && k < hist.size(); k++) hist[k].v = 1'b0;
        n.v  = v && !es && !fl && m_writes(i);
        n.rd = n.v ? int'(i[11:7]) : 0;
        n.ld = n.v && (i[6:0] == OP_LD);
        hist.push_front(n);
        void'(hist.pop_back());
        if (es) m_count++;
    endfunction

    function automatic void m_reset();
        m_ent_t b;
        b.v = 1'b0; b.rd = 0; b.ld = 1'b0;
        hist.delete();
        for (int k = 0; k < DEPTH; k++) hist.push_back(b);
        m_count = 0;
    endfunction

    // One cycle, starting just after a rising edge: drive, compare to the
    // model mid-cycle, then advance both on the edge.
    task automatic run_cycle(input bit v, input bit [31:0] i, input bit fl, input string tag);
        int ea, eb;
        bit es;
        issue_valid = v;
        issue_inst  = i;
        flush       = fl;
        #2;
        m_predict(v, i, fl, ea, eb, es);
        check({tag, " sel_ra"}, sel_ra, ea);
        check({tag, " sel_rb"}, sel_rb, eb);
        check({tag, " stall"}, stall, es);
        @(posedge clk);
        m_advance(v, i, fl, es);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit        v;
        bit [31:0] inst;
        bit        fl;
        int        ea;
        int        eb;
        bit        es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit v, input bit [31:0] i, input int ea,
                                    input int eb, input bit es);
        vec_t r;
        r.v = v; r.inst = i; r.fl = 1'b0; r.ea = ea; r.eb = eb; r.es = es;
        vecs.push_back(r);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] nop;
        bit [31:0] lw8;
        bit [31:0] use8;
        bit [31:0] cur;
        bit        hold;
        int        cnt_before;

        nop  = enc(OP_I, 0, 0, 0, 3'b000);
        lw8  = enc(OP_LD, 8, 2, 0, 3'b010);
        use8 = enc(OP_R, 9, 8, 0, 3'b000);

        // Back-to-back ALU
        add_vec(1, enc(OP_I, 5, 0, 1, 0), 0, 0, 0);
        add_vec(1, enc(OP_R, 6, 5, 5, 0), 1, 1, 0);
        // Youngest wins
        add_vec(1, enc(OP_I, 5, 0, 1, 0), 0, 0, 0);
        add_vec(1, enc(OP_I, 5, 0, 2, 0), 0, 0, 0);
        add_vec(1, enc(OP_R, 7, 5, 0, 0), 1, 0, 0);
        // Youngest wins across a nop
        add_vec(1, enc(OP_I, 5, 0, 3, 0), 0, 0, 0);
        add_vec(1, nop,                   0, 0, 0);
        add_vec(1, enc(OP_I, 5, 0, 4, 0), 0, 0, 0);
        add_vec(1, enc(OP_R, 7, 5, 0, 0), 1, 0, 0);
        // Producer behind a nop forwards from entry 1
        add_vec(1, enc(OP_I, 5, 0, 1, 0), 0, 0, 0);
        add_vec(1, nop,                   0, 0, 0);
        add_vec(1, enc(OP_R, 7, 5, 0, 0), 2, 0, 0);
        add_vec(1, nop,                   0, 0, 0);
        add_vec(1, nop,                   0, 0, 0);
        // Load-use: two stall cycles then forward from entry 2
        add_vec(1, lw8,                      0, 0, 0);
        add_vec(1, enc(OP_R, 9, 8, 1, 0),    0, 0, 1);
        add_vec(1, enc(OP_R, 9, 8, 1, 0),    0, 0, 1);
        add_vec(1, enc(OP_R, 9, 8, 1, 0),    3, 0, 0);
        // x0 never matches
        add_vec(1, enc(OP_I, 0, 0, 5, 0),    0, 0, 0);
        add_vec(1, enc(OP_R, 1, 0, 0, 0),    0, 0, 0);
        // LUI consumer: its rs fields would hit x3/x1 if treated as reads
        add_vec(1, enc(OP_I, 3, 0, 7, 0),    0, 0, 0);
        add_vec(1, enc(OP_LUI, 4, 3, 1, 0),  0, 0, 0);
        // CSR register form reads rs1, immediate form does not
        add_vec(1, enc(OP_SYS, 10, 3, 4, 3'b001), 2, 0, 0);
        add_vec(1, enc(OP_SYS, 10, 3, 4, 3'b101), 0, 0, 0);
        // Store reads both operands from the oldest entry
        add_vec(1, enc(OP_ST, 0, 4, 4, 3'b010),   3, 3, 0);
        add_vec(1, enc(OP_BR, 0, 0, 0, 0),        0, 0, 0);
        // issue_valid = 0 suppresses matching
        add_vec(1, enc(OP_I, 1, 0, 1, 0),    0, 0, 0);
        add_vec(0, enc(OP_R, 2, 1, 1, 0),    0, 0, 0);
        add_vec(1, enc(OP_R, 2, 1, 1, 0),    2, 2, 0);
        // JAL writes rd; branch reads both
        add_vec(1, enc(OP_JAL, 12, 0, 0, 0), 0, 0, 0);
        add_vec(1, enc(OP_BR, 0, 12, 2, 0),  1, 2, 0);

        // ---------------- Reset state ----------------
        rst = 1'b1; issue_valid = 1'b1; issue_inst = use8; flush = 1'b0;
        m_reset();
        #3;
        check("reset stall", stall, 0);
        check("reset sel_ra", sel_ra, 0);
        check("reset count", stall_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_valid = 1'b0;

        // ---------------- Table ----------------
        for (int n = 0; n < vecs.size(); n++) begin
            int ea, eb;
            bit es;
            issue_valid = vecs[n].v;
            issue_inst  = vecs[n].inst;
            flush       = vecs[n].fl;
            #2;
            check($sformatf("vec%0d sel_ra", n), sel_ra, vecs[n].ea);
            check($sformatf("vec%0d sel_rb", n), sel_rb, vecs[n].eb);
            check($sformatf("vec%0d stall", n), stall, vecs[n].es);
            m_predict(vecs[n].v, vecs[n].inst, vecs[n].fl, ea, eb, es);
            @(posedge clk);
            m_advance(vecs[n].v, vecs[n].inst, vecs[n].fl, es);
            #1;
        end
        check("table stall_count", stall_count, 2);

        // ---------------- Flush during a load-use stall ----------------
        for (int n = 0; n < 3; n++) run_cycle(1, nop, 0, "flush pre");
        cnt_before = int'(stall_count);
        run_cycle(1, lw8,  0, "flush lw");
        run_cycle(1, use8, 1, "flush hit");
        run_cycle(1, use8, 0, "flush after");
        check("flush sel_ra after kill", sel_ra, 0);
        check("flush count held", stall_count, cnt_before);

        // ---------------- Random vs model ----------------
        hold = 1'b0;
        cur  = nop;
        for (int n = 0; n < 500; n++) begin
            bit [6:0] ops[10] = '{OP_R, OP_I, OP_LD, OP_LD, OP_ST, OP_BR,
                                  OP_JALR, OP_LUI, OP_JAL, OP_SYS};
            bit v, fl, es;
            int ea, eb;
            if (!hold) begin
                cur = enc(ops[$urandom_range(0, 9)], $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          3'($urandom_range(0, 7)));
            end
            v  = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 7) == 0);
            m_predict(v, cur, fl, ea, eb, es);
            run_cycle(v, cur, fl, "rand");
            hold = es;
        end
        check("rand stall_count", stall_count, m_count);
        check("rand sat_count", sat_count, (m_count > 3) ? 3 : m_count);

        // ---------------- Async reset mid-stall ----------------
        for (int n = 0; n < 3; n++) run_cycle(1, nop, 0, "areset pre");
        run_cycle(1, lw8, 0, "areset lw");
        issue_valid = 1'b1; issue_inst = use8; flush = 1'b0;
        #2;
        check("areset stall before", stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check("areset stall drops", stall, 0);
        check("areset sel_ra", sel_ra, 0);
        check("areset count", stall_count, 0);
        check("areset sat_count", sat_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();

        // ---------------- Counter saturation (CNT_W = 2) ----------------
        run_cycle(1, lw8, 0, "sat lw1");
        for (int n = 0; n < 3; n++) run_cycle(1, use8, 0, "sat use1");
        check("sat count after 2", sat_count, 2);
        run_cycle(1, lw8, 0, "sat lw2");
        for (int n = 0; n < 3; n++) run_cycle(1, use8, 0, "sat use2");
        run_cycle(1, lw8, 0, "sat lw3");
        run_cycle(1, nop, 0, "sat nop");
        for (int n = 0; n < 2; n++) run_cycle(1, use8, 0, "sat use3");
        check("sat wide count", stall_count, 5);
        check("sat narrow count", sat_count, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
